// File: rtl/seq_adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle chunked adder.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk index width; a single-chunk adder still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder; exposes the carry into its top bit for overflow.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic c;

  always_comb begin
    c        = ci;
    s        = '0;
    c_msb_in = 1'b0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      c_msb_in = c;
      s[i]     = a[i] ^ b[i] ^ c;
      c        = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle ripple adder, CHUNK bits per clock, valid/ready on both sides.
// Define SEQ_ADDER_SUB_EN to add the 'sub' port (out = num1 - num2 when sub=1).
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             cin,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = num_chunks(WIDTH, CHUNK);
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("seq_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, out_q, out_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [CHUNK-1:0]   a_chunk, b_chunk, sum_s;
  logic               sum_co, sum_msb_in, op_sub;
  int                 base;

`ifdef SEQ_ADDER_SUB_EN
  assign op_sub = sub;
`else
  assign op_sub = 1'b0;
`endif

  always_comb begin
    base    = int'(idx_q) * CHUNK;
    a_chunk = a_q[base +: CHUNK];
    b_chunk = b_q[base +: CHUNK];
  end

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a        (a_chunk),
    .b        (b_chunk),
    .ci       (carry_q),
    .s        (sum_s),
    .co       (sum_co),
    .c_msb_in (sum_msb_in)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = num1;
          // Subtraction is a + ~b + 1, so the carry seed replaces cin.
          b_d     = op_sub ? ~num2 : num2;
          carry_d = op_sub | cin;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        out_d[base +: CHUNK] = sum_s;
        carry_d              = sum_co;
        idx_d                = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = sum_co;
          ovf_d   = sum_msb_in ^ sum_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder: 16/4 instance with random traffic, 4/1 instance exhaustive.
module tb_seq_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 16-bit, 4-bit chunk instance
  logic        in_valid_a = 1'b0, out_ready_a = 1'b0, cin_a = 1'b0, sub_a = 1'b0;
  logic        in_ready_a, out_valid_a, cout_a, ovf_a;
  logic [15:0] num1_a = '0, num2_a = '0, out_a;

  // 4-bit, 1-bit chunk instance
  logic        in_valid_b = 1'b0, out_ready_b = 1'b0, sub_b = 1'b0;
  logic        in_ready_b, out_valid_b, cout_b, ovf_b;
  logic [3:0]  num1_b = '0, num2_b = '0, out_b;

  seq_adder #(.WIDTH(16), .CHUNK(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .num1(num1_a), .num2(num2_a), .cin(cin_a),
`ifdef SEQ_ADDER_SUB_EN
    .sub(sub_a),
`endif
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out(out_a), .cout(cout_a), .ovf(ovf_a)
  );

  seq_adder #(.WIDTH(4), .CHUNK(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .num1(num1_b), .num2(num2_b), .cin(1'b0),
`ifdef SEQ_ADDER_SUB_EN
    .sub(sub_b),
`endif
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out(out_b), .cout(cout_b), .ovf(ovf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, out} from integer arithmetic on the operands.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic s);
    int sa, sb, r;
    logic [16:0] full;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      full = {(a >= b), 16'(a - b)};
      r    = sa - sb;
    end else begin
      full = 17'(a) + 17'(b) + 17'(c);
      r    = sa + sb + int'(c);
    end
    return {(r > 32767 || r < -32768), full};
  endfunction

  // One transaction on dut_a. If pend is set, new operands are left presented
  // (in_valid high) throughout BUSY/DONE so they are taken right after the handshake.
  task automatic txn16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                       input int unsigned stall, input logic pend,
                       input logic [15:0] pa, input logic [15:0] pb);
    logic [17:0] exp;
    int unsigned edges;
    exp = model16(a, b, c, s);
    edges = 0;
    while (!in_ready_a && edges < 50) begin tick(); edges++; end
    check("in_ready_before_accept", in_ready_a, 1);
    num1_a = a; num2_a = b; cin_a = c; sub_a = s; in_valid_a = 1'b1;
    tick();
    if (pend) begin
      num1_a = pa; num2_a = pb; cin_a = 1'b0; sub_a = 1'b0; in_valid_a = 1'b1;
    end else begin
      in_valid_a = 1'b0;
      num1_a = 16'($urandom); num2_a = 16'($urandom); cin_a = 1'($urandom); sub_a = 1'($urandom);
    end
    check("in_ready_busy", in_ready_a, 0);
    edges = 0;
    while (!out_valid_a && edges < 20) begin tick(); edges++; end
    check("latency_edges", edges, 4);
    check("sum_out", out_a, exp[15:0]);
    check("sum_cout", cout_a, exp[16]);
    check("sum_ovf", ovf_a, exp[17]);
    for (int unsigned i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", out_valid_a, 1);
      check("stall_in_ready", in_ready_a, 0);
      check("stall_result", {cout_a, ovf_a, out_a}, {exp[16], exp[17], exp[15:0]});
    end
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    check("post_hs_valid", out_valid_a, 0);
    check("post_hs_in_ready", in_ready_a, 1);
    check("post_hs_held_out", out_a, exp[15:0]);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                      input logic [4:0] exp);
    int unsigned edges;
    edges = 0;
    while (!in_ready_b && edges < 50) begin tick(); edges++; end
    num1_b = a; num2_b = b; sub_b = s; in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    edges = 0;
    while (!out_valid_b && edges < 20) begin tick(); edges++; end
    check("w4_result", {cout_b, out_b}, exp);
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc, rs;

    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready_a, 1);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out", out_a, 0);
    check("rst_cout_ovf", {cout_a, ovf_a}, 0);

    txn16(16'h0000, 16'h0001, 1'b0, 1'b0, 0, 1'b0, '0, '0);
    txn16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, '0, '0);
    txn16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 1'b0, '0, '0);
    txn16(16'h1234, 16'h0000, 1'b1, 1'b0, 0, 1'b0, '0, '0);
    txn16(16'h1234, 16'h0000, 1'b0, 1'b0, 0, 1'b0, '0, '0);

    // Backpressure with new operands waiting, then the waiting operands.
    txn16(16'h8000, 16'h8000, 1'b1, 1'b0, 5, 1'b1, 16'h0F0F, 16'h00F1);
    txn16(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, 1'b0, '0, '0);

    // Reset during the second BUSY cycle.
    num1_a = 16'hABCD; num2_a = 16'h1111; cin_a = 1'b1; in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", out_valid_a, 0);
    check("midrst_out", out_a, 0);
    check("midrst_in_ready", in_ready_a, 1);
    check("midrst_cout_ovf", {cout_a, ovf_a}, 0);
    txn16(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, '0, '0);

    // rst and in_valid together: nothing accepted.
    rst = 1'b1; in_valid_a = 1'b1; num1_a = 16'h0005; num2_a = 16'h0006;
    tick();
    rst = 1'b0; in_valid_a = 1'b0;
    check("rst_vs_valid_idle", in_ready_a, 1);
    tick();
    check("rst_vs_valid_still_idle", {in_ready_a, out_valid_a}, 2'b10);

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
`ifdef SEQ_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      txn16(ra, rb, rc, rs, $urandom_range(0, 3), 1'b0, '0, '0);
    end

`ifdef SEQ_ADDER_SUB_EN
    txn16(16'h0003, 16'h0005, 1'b0, 1'b1, 0, 1'b0, '0, '0);
    txn16(16'h8000, 16'h0001, 1'b1, 1'b1, 0, 1'b0, '0, '0);
    run4(4'h3, 4'h5, 1'b1, 5'h0E);
`endif

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run4(4'(a), 4'(b), 1'b0, 5'(a + b));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
